// File: rtl/fetch_pipe.sv
// Instruction fetch front end: issues sequential PC requests to an in-order cache,
// buffers returned words in a small ring, and discards responses orphaned by a redirect.
module fetch_pipe #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_ready,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  output logic            rsp_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW:0]   DepthSum = (CntW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PcStep   = XLEN'(ILEN / 8);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  ent_pc_q    [DEPTH];
  logic [ILEN-1:0]  ent_instr_q [DEPTH];
  logic [DEPTH-1:0] ent_filled_q;
  logic [PtrW-1:0]  alloc_ptr_q;
  logic [PtrW-1:0]  fill_ptr_q;
  logic [PtrW-1:0]  head_ptr_q;
  logic [CntW-1:0]  alloc_cnt_q;
  logic [CntW-1:0]  stale_cnt_q;

  logic            issue;
  logic            rsp_acc;
  logic            rsp_stale;
  logic            rsp_fill;
  logic            pop;
  logic [CntW-1:0] filled_cnt;
  logic [CntW-1:0] unfilled_cnt;

  // Handshake decode; credits count stale in-flight requests so the ring can never overflow.
  always_comb begin
    req_valid = !redirect_valid &&
                (({1'b0, alloc_cnt_q} + {1'b0, stale_cnt_q}) < DepthSum);
    req_addr  = pc_q;
    rsp_ready = 1'b1;
    out_valid = ent_filled_q[head_ptr_q] && (alloc_cnt_q != '0) && !redirect_valid;
    out_pc    = ent_pc_q[head_ptr_q];
    out_instr = ent_instr_q[head_ptr_q];
    issue     = req_valid && req_ready;
    rsp_acc   = rsp_valid && rsp_ready;
    rsp_stale = rsp_acc && (stale_cnt_q != '0);
    // A response landing in the redirect cycle belongs to the old stream.
    rsp_fill  = rsp_acc && (stale_cnt_q == '0) && !redirect_valid;
    pop       = out_valid && out_ready;
  end

  // Allocated-but-unfilled entries become stale on redirect; their responses are still coming.
  always_comb begin
    filled_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CntW'(ent_filled_q[i]);
    end
    unfilled_cnt = alloc_cnt_q - filled_cnt;
  end

  // Control state: PC, pointers, counters and per-entry filled flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q         <= RESET_PC;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      alloc_cnt_q  <= '0;
      stale_cnt_q  <= '0;
      ent_filled_q <= '0;
    end else if (redirect_valid) begin
      pc_q         <= redirect_pc;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      alloc_cnt_q  <= '0;
      ent_filled_q <= '0;
      stale_cnt_q  <= stale_cnt_q + unfilled_cnt - CntW'(rsp_acc);
    end else begin
      if (rsp_stale) begin
        stale_cnt_q <= stale_cnt_q - CntW'(1);
      end
      if (pop) begin
        ent_filled_q[head_ptr_q] <= 1'b0;
        head_ptr_q               <= head_ptr_q + PtrW'(1);
      end
      if (rsp_fill) begin
        ent_filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q               <= fill_ptr_q + PtrW'(1);
      end
      if (issue) begin
        ent_filled_q[alloc_ptr_q] <= 1'b0;
        alloc_ptr_q               <= alloc_ptr_q + PtrW'(1);
        pc_q                      <= pc_q + PcStep;
      end
      alloc_cnt_q <= alloc_cnt_q + CntW'(issue) - CntW'(pop);
    end
  end

  // Entry payload storage; only meaningful while the matching filled flag says so.
  always_ff @(posedge clk) begin
    if (rstn && issue) begin
      ent_pc_q[alloc_ptr_q] <= pc_q;
    end
    if (rstn && rsp_fill) begin
      ent_instr_q[fill_ptr_q] <= rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: in-order cache model with 1-cycle response latency plus a
// scoreboard of expected {pc, instr} pushed at issue and popped at delivery.
module tb_fetch_pipe;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            req_ready = 1'b0;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid = 1'b0;
  logic [ILEN-1:0] rsp_data = '0;
  logic            rsp_ready;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_pipe #(
    .XLEN    (XLEN),
    .ILEN    (ILEN),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_ready     (req_ready),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_ready     (out_ready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] cache_q[$];
  exp_t        sb[$];
  logic [63:0] issue_log[$];
  logic [63:0] model_pc = RESET_PC;
  bit          rsp_en = 1'b0;
  int          cyc = 0;
  int          n_issue = 0;
  int          n_pop = 0;
  int          first_issue_cyc = -1;
  int          first_out_cyc = -1;
  bit          got_pop = 1'b0;
  logic [63:0] first_pop_pc = '0;
  bit          held_valid = 1'b0;
  logic [63:0] held_pc = '0;
  logic [31:0] held_instr = '0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: drive cache response, sample mid-cycle, update models, advance past the edge.
  task automatic tick();
    exp_t e;
    if (rstn && rsp_en && cache_q.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(cache_q[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #4;
    if (rstn) begin
      check("rsp_ready", 64'(rsp_ready), 64'd1);
      if (redirect_valid) begin
        check("redir_req_valid", 64'(req_valid), 64'd0);
        check("redir_out_valid", 64'(out_valid), 64'd0);
      end
      if (held_valid && !redirect_valid) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_pc", out_pc, held_pc);
        check("hold_instr", 64'(out_instr), 64'(held_instr));
      end
      if (rsp_valid && rsp_ready && cache_q.size() > 0) void'(cache_q.pop_front());
      if (req_valid && req_ready) begin
        check("req_addr", req_addr, model_pc);
        cache_q.push_back(req_addr);
        issue_log.push_back(req_addr);
        sb.push_back('{pc: model_pc, instr: instr_of(model_pc)});
        model_pc = model_pc + 64'd4;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        n_issue++;
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", 64'(out_instr), 64'(e.instr));
        end
        if (!got_pop) begin
          got_pop       = 1'b1;
          first_pop_pc  = out_pc;
          first_out_cyc = cyc;
        end
        n_pop++;
      end
      held_valid = out_valid && !out_ready && !redirect_valid;
      held_pc    = out_pc;
      held_instr = out_instr;
      if (redirect_valid) begin
        sb.delete();
        model_pc = redirect_pc;
      end
    end else begin
      held_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_phase();
    n_issue         = 0;
    n_pop           = 0;
    got_pop         = 1'b0;
    first_issue_cyc = -1;
    first_out_cyc   = -1;
    issue_log.delete();
  endtask

  // Cache and bench models are reset together with the DUT.
  task automatic do_reset();
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    cache_q.delete();
    sb.delete();
    model_pc       = RESET_PC;
    held_valid     = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready), 64'd1);
    check("rst_alloc", 64'(dut.alloc_cnt_q), 64'd0);
    check("rst_stale", 64'(dut.stale_cnt_q), 64'd0);
    rstn = 1'b1;
    #1;
    check("rel_req_valid", 64'(req_valid), 64'd1);
    check("rel_req_addr", req_addr, RESET_PC);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Streaming: one instruction per cycle, first delivery two cycles after first issue.
    start_phase();
    req_ready = 1'b1;
    rsp_en    = 1'b1;
    out_ready = 1'b1;
    repeat (20) tick();
    check("stream_issues", 64'(n_issue), 64'd20);
    check("stream_pops", 64'(n_pop), 64'd18);
    check("stream_latency", 64'(first_out_cyc - first_issue_cyc), 64'd2);
    check("stream_first_pc", first_pop_pc, RESET_PC);

    // Backpressure: ring fills to DEPTH, issue stops, head holds.
    do_reset();
    start_phase();
    out_ready = 1'b0;
    repeat (10) tick();
    check("bp_issues", 64'(n_issue), 64'd4);
    check("bp_req_valid", 64'(req_valid), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_out_pc", out_pc, RESET_PC);
    out_ready = 1'b1;
    repeat (10) tick();
    check("bp_resume", 64'(n_issue > 4), 64'd1);
    check("bp_first_pop", first_pop_pc, RESET_PC);

    // Redirect with three unfilled requests in flight.
    do_reset();
    start_phase();
    rsp_en = 1'b0;
    repeat (3) tick();
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    check("rd_stale", 64'(dut.stale_cnt_q), 64'd3);
    check("rd_alloc", 64'(dut.alloc_cnt_q), 64'd0);
    start_phase();
    req_ready = 1'b1;
    rsp_en    = 1'b1;
    repeat (12) tick();
    check("rd_got_pop", 64'(got_pop), 64'd1);
    check("rd_first_pc", first_pop_pc, 64'h8000_1000);

    // Redirect coinciding with a response while the head is poppable.
    do_reset();
    start_phase();
    rsp_en = 1'b0;
    repeat (3) tick();
    req_ready = 1'b0;
    rsp_en    = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    check("rr_pops", 64'(n_pop), 64'd0);
    check("rr_stale", 64'(dut.stale_cnt_q), 64'd1);
    start_phase();
    req_ready = 1'b1;
    repeat (10) tick();
    check("rr_first_pc", first_pop_pc, 64'h8000_2000);

    // PC wrap at the top of the address space.
    start_phase();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    check("wrap_n", 64'(issue_log.size() >= 2), 64'd1);
    if (issue_log.size() >= 2) begin
      check("wrap_a0", issue_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_a1", issue_log[1], 64'h0);
    end
    check("wrap_first_pc", first_pop_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset in the middle of operation with the ring full.
    start_phase();
    out_ready = 1'b0;
    repeat (8) tick();
    check("full_alloc", 64'(dut.alloc_cnt_q), 64'd4);
    rstn = 1'b0;
    cache_q.delete();
    sb.delete();
    model_pc   = RESET_PC;
    held_valid = 1'b0;
    tick();
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_req_addr", req_addr, RESET_PC);
    check("mr_alloc", 64'(dut.alloc_cnt_q), 64'd0);
    check("mr_stale", 64'(dut.stale_cnt_q), 64'd0);
    rstn = 1'b1;
    start_phase();
    out_ready = 1'b1;
    repeat (8) tick();
    check("mr_first_pc", first_pop_pc, RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
